// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared page encodings, digit geometry and source selection for the display scheduler
package display_pkg;

  localparam logic [1:0] PAGE_SCORE = 2'd0;
  localparam logic [1:0] PAGE_TIMER = 2'd1;
  localparam logic [1:0] PAGE_MSG   = 2'd2;

  localparam int DIGIT_W = 4;
  localparam int DIGITS  = 4;

  // State codes equal the page codes so the state register drives `page` directly.
  typedef enum logic [1:0] {
    ST_SCORE = PAGE_SCORE,
    ST_TIMER = PAGE_TIMER,
    ST_MSG   = PAGE_MSG
  } state_e;

  // Live source shown for a page state; the message page never reaches this.
  function automatic logic [DIGITS*DIGIT_W-1:0] pick_source(
    input state_e                      s,
    input logic [DIGITS*DIGIT_W-1:0]   score,
    input logic [DIGITS*DIGIT_W-1:0]   timer
  );
    return (s == ST_TIMER) ? timer : score;
  endfunction

endpackage

// File: rtl/tick_down_counter.sv
// rtl/tick_down_counter.sv - loadable down counter that decrements on enable and saturates at zero
module tick_down_counter #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         zero_o
);

  logic [W-1:0] count_q, count_d;

  // Load wins over decrement; decrement stops at zero so a stray tick cannot wrap.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/display_sched.sv
// rtl/display_sched.sv - rotates score/timer pages on ticks and preempts them with held one-shot messages
module display_sched
  import display_pkg::*;
#(
  parameter int PAGE_TICKS = 4,
  parameter int HOLD_TICKS = 3
) (
  input  logic        master_clock,
  input  logic        rst,
  input  logic        tick,
  input  logic [15:0] score_digits,
  input  logic [15:0] timer_digits,
  input  logic        msg_req,
  input  logic [15:0] msg_digits,
  input  logic        msg_blink,
  output logic        msg_ack,
  output logic [3:0]  digit_1,
  output logic [3:0]  digit_2,
  output logic [3:0]  digit_3,
  output logic [3:0]  digit_4,
  output logic        blink_en,
  output logic [1:0]  page
);

  localparam int PW = $clog2(PAGE_TICKS + 1);
  localparam int HW = $clog2(HOLD_TICKS + 1);

  state_e         state_q, state_d;
  state_e         ret_q, ret_d;
  logic [PW-1:0]  page_cnt_q, page_cnt_d;
  logic [15:0]    disp_q, disp_d;
  logic           blink_q, blink_d;
  logic           ack_q, ack_d;

  logic           hold_load;
  logic           hold_dec;
  logic [HW-1:0]  hold_cnt;
  logic           hold_zero;

  tick_down_counter #(
    .W (HW)
  ) u_hold (
    .clk_i      (master_clock),
    .rst_ni     (rst),
    .load_i     (hold_load),
    .load_val_i (HW'(HOLD_TICKS)),
    .dec_i      (hold_dec),
    .count_o    (hold_cnt),
    .zero_o     (hold_zero)
  );

  // Next state and next registered outputs: accept beats rotation, message holds until its last tick.
  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    page_cnt_d = page_cnt_q;
    disp_d     = disp_q;
    blink_d    = blink_q;
    ack_d      = 1'b0;
    hold_load  = 1'b0;
    hold_dec   = 1'b0;

    case (state_q)
      ST_SCORE, ST_TIMER: begin
        if (msg_req) begin
          disp_d    = msg_digits;
          blink_d   = msg_blink;
          ret_d     = state_q;
          hold_load = 1'b1;
          ack_d     = 1'b1;
          state_d   = ST_MSG;
        end else begin
          if (tick) begin
            if (page_cnt_q == PW'(PAGE_TICKS - 1)) begin
              page_cnt_d = '0;
              state_d    = (state_q == ST_SCORE) ? ST_TIMER : ST_SCORE;
            end else begin
              page_cnt_d = page_cnt_q + 1'b1;
            end
          end
          disp_d  = pick_source(state_d, score_digits, timer_digits);
          blink_d = 1'b0;
        end
      end

      ST_MSG: begin
        if (tick) begin
          hold_dec = 1'b1;
          // A zero count here would mean a lost load; leave rather than stick in the message page.
          if (hold_zero || (hold_cnt == HW'(1))) begin
            state_d    = ret_q;
            page_cnt_d = '0;
            disp_d     = pick_source(ret_q, score_digits, timer_digits);
            blink_d    = 1'b0;
          end
        end
      end

      default: begin
        state_d    = ST_SCORE;
        page_cnt_d = '0;
        blink_d    = 1'b0;
      end
    endcase
  end

  // State, return page, rotation count and all registered outputs.
  always_ff @(posedge master_clock or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_SCORE;
      ret_q      <= ST_SCORE;
      page_cnt_q <= '0;
      disp_q     <= '0;
      blink_q    <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      page_cnt_q <= page_cnt_d;
      disp_q     <= disp_d;
      blink_q    <= blink_d;
      ack_q      <= ack_d;
    end
  end

  assign page     = state_q;
  assign msg_ack  = ack_q;
  assign blink_en = blink_q;
  assign digit_1  = disp_q[15:12];
  assign digit_2  = disp_q[11:8];
  assign digit_3  = disp_q[7:4];
  assign digit_4  = disp_q[3:0];

endmodule

// File: tb/tb_display_sched.sv
// tb/tb_display_sched.sv - randomized and directed self-checking bench for display_sched
`timescale 1ns/1ps
module tb_display_sched;

  localparam int PAGE = 4;
  localparam int HOLD = 3;

  logic        master_clock = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic [15:0] score_digits = '0;
  logic [15:0] timer_digits = '0;
  logic        msg_req = 1'b0;
  logic [15:0] msg_digits = '0;
  logic        msg_blink = 1'b0;
  logic        msg_ack;
  logic [3:0]  digit_1, digit_2, digit_3, digit_4;
  logic        blink_en;
  logic [1:0]  page;

  int vecs = 0;
  int errs = 0;

  // Reference model: which page is up, ticks spent on it, ticks left on a message.
  int          m_page;
  int          m_ret;
  int          m_cnt;
  int          m_hold;
  logic [15:0] m_disp;
  logic        m_blink;
  logic        m_ack;

  display_sched #(
    .PAGE_TICKS (PAGE),
    .HOLD_TICKS (HOLD)
  ) dut (
    .master_clock (master_clock),
    .rst          (rst),
    .tick         (tick),
    .score_digits (score_digits),
    .timer_digits (timer_digits),
    .msg_req      (msg_req),
    .msg_digits   (msg_digits),
    .msg_blink    (msg_blink),
    .msg_ack      (msg_ack),
    .digit_1      (digit_1),
    .digit_2      (digit_2),
    .digit_3      (digit_3),
    .digit_4      (digit_4),
    .blink_en     (blink_en),
    .page         (page)
  );

  always #5 master_clock = ~master_clock;

  wire [15:0] dut_digits = {digit_1, digit_2, digit_3, digit_4};
  wire [19:0] dut_vec    = {page, msg_ack, blink_en, dut_digits};

  function automatic logic [19:0] exp_vec();
    return {2'(m_page), m_ack, m_blink, m_disp};
  endfunction

  task automatic model_reset();
    m_page  = 0;
    m_ret   = 0;
    m_cnt   = 0;
    m_hold  = 0;
    m_disp  = '0;
    m_blink = 1'b0;
    m_ack   = 1'b0;
  endtask

  // One clock edge for DUT and model; returns 1 ns after the edge.
  task automatic step();
    @(posedge master_clock);
    if (!rst) begin
      model_reset();
    end else if (m_page != 2) begin
      if (msg_req) begin
        m_disp  = msg_digits;
        m_blink = msg_blink;
        m_ret   = m_page;
        m_hold  = HOLD;
        m_ack   = 1'b1;
        m_page  = 2;
      end else begin
        m_ack = 1'b0;
        if (tick) begin
          m_cnt = m_cnt + 1;
          if (m_cnt == PAGE) begin
            m_cnt  = 0;
            m_page = 1 - m_page;
          end
        end
        m_disp  = (m_page == 0) ? score_digits : timer_digits;
        m_blink = 1'b0;
      end
    end else begin
      m_ack = 1'b0;
      if (tick) begin
        m_hold = m_hold - 1;
        if (m_hold == 0) begin
          m_page  = m_ret;
          m_cnt   = 0;
          m_disp  = (m_page == 0) ? score_digits : timer_digits;
          m_blink = 1'b0;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      tick         = 1'($urandom_range(0, 1));
      msg_req      = 1'($urandom_range(0, 1));
      msg_blink    = 1'($urandom_range(0, 1));
      msg_digits   = 16'($urandom);
      score_digits = 16'($urandom);
      timer_digits = 16'($urandom);
      step();
      vecs++;
      if (dut_vec !== 20'h0) begin
        errs++;
        $display("FAIL reset_hold cyc %0d got %h want %h", i, dut_vec, 20'h0);
      end
    end
    tick         = 1'b0;
    msg_req      = 1'b0;
    score_digits = 16'h1234;
    timer_digits = 16'h5678;
    rst          = 1'b1;
    step();
    vecs++;
    if (dut_digits !== 16'h1234 || page !== 2'd0) begin
      errs++;
      $display("FAIL reset_release got digits %h page %0d want 1234 page 0", dut_digits, page);
    end
  endtask

  task automatic test_rotation();
    int ticks = 0;
    score_digits = 16'h0042;
    timer_digits = 16'h0130;
    for (int i = 0; i < 18; i++) begin
      tick = (i % 2 == 1);
      if (i >= 10) begin
        score_digits = 16'($urandom);
        timer_digits = 16'($urandom);
      end
      step();
      if (tick) ticks++;
      vecs++;
      if (dut_vec !== exp_vec()) begin
        errs++;
        $display("FAIL rotation cyc %0d got %h want %h", i, dut_vec, exp_vec());
      end
      if (tick && (ticks == 4 || ticks == 8)) begin
        vecs++;
        if (page !== ((ticks == 4) ? 2'd1 : 2'd0)) begin
          errs++;
          $display("FAIL rotation_page after tick %0d got %0d want %0d", ticks, page, (ticks == 4) ? 1 : 0);
        end
      end
    end
    tick = 1'b0;
  endtask

  task automatic test_message();
    score_digits = 16'h0042;
    timer_digits = 16'h0130;
    for (int i = 0; i < 6; i++) begin
      tick = 1'b1;
      step();
    end
    tick       = 1'b0;
    msg_req    = 1'b1;
    msg_digits = 16'hE0D0;
    msg_blink  = 1'b1;
    step();
    vecs++;
    if (dut_vec !== {2'd2, 1'b1, 1'b1, 16'hE0D0}) begin
      errs++;
      $display("FAIL msg_accept got %h want %h", dut_vec, {2'd2, 1'b1, 1'b1, 16'hE0D0});
    end
    msg_req = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick = (i % 2 == 0);
      step();
      vecs++;
      if (dut_vec !== exp_vec()) begin
        errs++;
        $display("FAIL msg_hold cyc %0d got %h want %h", i, dut_vec, exp_vec());
      end
      if (i == 4 || i == 10) begin
        vecs++;
        if (page !== ((i == 4) ? 2'd1 : 2'd1)) begin
          errs++;
          $display("FAIL msg_return cyc %0d got page %0d want 1", i, page);
        end
      end
    end
    tick = 1'b1;
    step();
    tick = 1'b0;
    vecs++;
    if (page !== 2'd0 || dut_digits !== 16'h0042) begin
      errs++;
      $display("FAIL msg_rotate_after got page %0d digits %h want 0 0042", page, dut_digits);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1;
      step();
    end
    tick       = 1'b1;
    msg_req    = 1'b1;
    msg_digits = 16'h0E4D;
    msg_blink  = 1'b0;
    step();
    vecs++;
    if (page !== 2'd2 || msg_ack !== 1'b1 || blink_en !== 1'b0) begin
      errs++;
      $display("FAIL simul_accept got page %0d ack %b blink %b want 2 1 0", page, msg_ack, blink_en);
    end
    msg_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1;
      step();
      vecs++;
      if (dut_vec !== exp_vec()) begin
        errs++;
        $display("FAIL simul_hold cyc %0d got %h want %h", i, dut_vec, exp_vec());
      end
    end
    tick = 1'b0;
    vecs++;
    if (page !== 2'd0) begin
      errs++;
      $display("FAIL simul_return got page %0d want 0", page);
    end
  endtask

  task automatic test_busy();
    msg_req    = 1'b1;
    msg_digits = 16'hAAAA;
    step();
    msg_req    = 1'b0;
    step();
    msg_req    = 1'b1;
    msg_digits = 16'hBBBB;
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      vecs++;
      if (msg_ack !== 1'b0) begin
        errs++;
        $display("FAIL busy_noack cyc %0d got ack %b want 0", i, msg_ack);
      end
    end
    vecs++;
    if (page !== 2'd0) begin
      errs++;
      $display("FAIL busy_exit got page %0d want 0", page);
    end
    step();
    vecs++;
    if (msg_ack !== 1'b1 || page !== 2'd2 || dut_digits !== 16'hBBBB) begin
      errs++;
      $display("FAIL busy_reaccept got ack %b page %0d digits %h want 1 2 bbbb", msg_ack, page, dut_digits);
    end
    msg_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1;
      step();
    end
    tick = 1'b0;
    vecs++;
    if (dut_vec !== exp_vec()) begin
      errs++;
      $display("FAIL busy_done got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_reset_mid_msg();
    msg_req    = 1'b1;
    msg_digits = 16'hC0DE;
    msg_blink  = 1'b1;
    step();
    msg_req = 1'b0;
    tick    = 1'b1;
    step();
    tick = 1'b0;
    rst  = 1'b0;
    model_reset();
    #1;
    vecs++;
    if (dut_vec !== 20'h0) begin
      errs++;
      $display("FAIL rst_mid_async got %h want %h", dut_vec, 20'h0);
    end
    step();
    step();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick = (i == 2);
      step();
      vecs++;
      if (msg_ack !== 1'b0 || dut_vec !== exp_vec()) begin
        errs++;
        $display("FAIL rst_mid_after cyc %0d got %h want %h", i, dut_vec, exp_vec());
      end
    end
    tick = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      if (msg_ack) begin
        msg_req = 1'b0;
      end else if (!msg_req && $urandom_range(0, 9) == 0) begin
        msg_req    = 1'b1;
        msg_digits = 16'($urandom);
        msg_blink  = 1'($urandom_range(0, 1));
      end
      tick         = ($urandom_range(0, 2) == 0);
      score_digits = 16'($urandom);
      timer_digits = 16'($urandom);
      step();
      vecs++;
      if (dut_vec !== exp_vec()) begin
        errs++;
        $display("FAIL random cyc %0d got %h want %h", i, dut_vec, exp_vec());
      end
    end
    msg_req = 1'b0;
    tick    = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rotation();
    test_message();
    test_simultaneous();
    test_busy();
    test_reset_mid_msg();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/display_sched.md
# display_sched

Display scheduler for the whack-a-mole 4-digit seven-segment display. It shares the single `display` instance between three sources: the live score, the round timer and one-shot event messages (e.g. "GO", "END"). Score and timer pages rotate on a tick count, and messages preempt the rotation for a fixed hold time. It sits between the game logic and `display`. Its `digit_1..digit_4` outputs drive the display inputs, and `blink_en` gates `clk_blink` blinking.

## Interface
- `PAGE_TICKS`, default 4: ticks each of score/timer page stays shown before rotating; legal range ≥1.
- `HOLD_TICKS`, default 3: ticks a message stays shown; legal range ≥1.
- `master_clock`  in  1  system clock; everything is synchronous to its rising edge.
- `rst`  in  1  reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `tick`  in  1  single-cycle strobe in the `master_clock` domain (game 1 Hz tick).
- `score_digits`  in  16  score BCD; [15:12]=digit_1 … [3:0]=digit_4.
- `timer_digits`  in  16  timer BCD; same packing.
- `msg_req`  in  1  message request, level; held until ack.
- `msg_digits`  in  16  message digit codes; valid while `msg_req`=1.
- `msg_blink`  in  1  message blinks; valid while `msg_req`=1.
- `msg_ack`  out  1  one-cycle pulse: message accepted.
- `digit_1`..`digit_4`  out  4 each  digits to `display`.
- `blink_en`  out  1  enable blinking in `display`.
- `page`  out  2  current source: 0 score, 1 timer, 2 message.

## Operation
- States:
  - `SCORE`: page 0, digits follow `score_digits`.
  - `TIMER`: page 1, digits follow `timer_digits`.
  - `MSG`: page 2, digits hold the captured message.
- Reset values:
  - state `SCORE`, `page`=0.
  - All digits 0, `blink_en`=0, `msg_ack`=0.
  - Page counter 0, hold counter 0, return-page register `SCORE`.
- Rotation, `SCORE`/`TIMER` only:
  - Page counter increments on `tick`.
  - On the tick that makes it equal `PAGE_TICKS`: counter clears and state toggles `SCORE`↔`TIMER`.
  - `blink_en`=0 in both pages.
- Message accept:
  - Condition: in `SCORE` or `TIMER` with `msg_req`=1.
  - Actions on that edge:
    - Capture `msg_digits`/`msg_blink`.
    - Record the current page as the return page.
    - Load hold counter with `HOLD_TICKS`.
    - Assert `msg_ack` for one cycle.
    - Go to `MSG`.
  - Accept has priority over a simultaneous rotation tick; that tick is dropped.
- `MSG`:
  - Hold counter decrements on `tick`.
  - On the tick that reaches 0: return to the recorded page with the page counter cleared.
  - `msg_req` is never acked while in `MSG`.
- Handshake:
  - Requester drops `msg_req` in the cycle after `msg_ack`.
  - A `msg_req` still high after return is treated as a new request and accepted in the first page-state cycle.
- Digit codes >9 pass through unchanged; `display` handles decoding and blanking.

## Timing
- All outputs are registered.
- Page states: digits equal the selected source sampled at the previous edge, i.e. 1-cycle latency.
- Accept edge E: from E onward, digits = captured message, `blink_en` = `msg_blink`, `page`=2, and `msg_ack`=1 for exactly the cycle after E.
- A `tick` coincident with the accept cycle is not counted toward the hold.
- Exit: after the edge consuming the `HOLD_TICKS`-th counted tick, `page` = return page and digits follow that source.
- Reset asserted mid-message: immediate return to reset values; message is lost and no ack is issued afterward.
- `tick` high for multiple cycles counts once per cycle; the tick source guarantees single-cycle strobes.

## Structure
- Shared package `display_pkg`:
  - page encodings `PAGE_SCORE`=0, `PAGE_TIMER`=1, `PAGE_MSG`=2;
  - `DIGIT_W`=4;
  - `DIGITS`=4.
- Sub-module `tick_down_counter`:
  - load value, tick-enable decrement, `zero` flag;
  - used for the message hold;
  - page rotation stays inline.
- Target ~150–250 lines RTL.

## Test plan
- Reset: hold `rst`=0 with random inputs → digits 0, `page`=0, `blink_en`=0, `msg_ack`=0; after release, digits = `score_digits` (0x1234 → 1,2,3,4) one cycle later.
- Rotation, `PAGE_TICKS`=4, score 0x0042, timer 0x0130: `page` goes 0→1 after the 4th tick, back to 0 after the 8th; digits track live inputs with 1-cycle latency.
- Message: in `TIMER` after 2 ticks, request 0xE0D0 with `msg_blink`=1 → one-cycle `msg_ack`, `page`=2, `blink_en`=1; after 3 ticks return to `page`=1, counter cleared (4 more ticks needed to rotate).
- Simultaneous: `msg_req` and the rotating `tick` in the same cycle → message accepted, tick dropped, return page = pre-rotation page.
- Busy: second `msg_req` held high during `MSG` → no ack until exit; acked on the first cycle back in the page state.
- Reset mid-message: pull `rst` low 1 tick into the hold → immediate reset values, no later `msg_ack` for the lost message.
